// File: rtl/logic_gate_pkg.sv
// Shared types for the logic gate unit: operation codes, beat modes and the
// frame-tracking FSM state.
package logic_gate_pkg;

    typedef enum logic [2:0] {
        OP_AND    = 3'd0,
        OP_OR     = 3'd1,
        OP_XOR    = 3'd2,
        OP_NAND   = 3'd3,
        OP_NOR    = 3'd4,
        OP_XNOR   = 3'd5,
        OP_NOT_A  = 3'd6,
        OP_PASS_A = 3'd7
    } op_e;

    localparam logic MODE_PAIR   = 1'b0;
    localparam logic MODE_REDUCE = 1'b1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_ACCUM = 1'b1
    } state_e;

    // Unary ops ignore the accumulator in reduce mode: the beat's own in_a wins.
    function automatic logic is_unary(input op_e op);
        return (op == OP_NOT_A) || (op == OP_PASS_A);
    endfunction

endpackage

// File: rtl/lgu_fifo.sv
// Synchronous FIFO with a combinational head; push and pop may occur on the same edge.
module lgu_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_din,
    input  logic         i_pop,
    output logic [W-1:0] o_dout,
    output logic         o_full,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] r_mem [DEPTH];
    logic [AW:0]  r_wr;
    logic [AW:0]  r_rd;
    logic         w_do_push;
    logic         w_do_pop;

    // The extra pointer bit tells a full ring apart from an empty one.
    assign o_empty   = (r_wr == r_rd);
    assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_dout    = r_mem[r_rd[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr <= '0;
            r_rd <= '0;
        end else begin
            if (w_do_push) r_wr <= r_wr + 1'b1;
            if (w_do_pop)  r_rd <= r_rd + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr[AW-1:0]] <= i_din;
    end

endmodule

// File: rtl/logic_gate_unit.sv
// Bitwise logic unit: pairwise beats produce one result each; reduce frames fold
// in_a across beats and emit a single result on the last beat.
module logic_gate_unit
    import logic_gate_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int CW    = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [2:0]       in_op,
    input  logic             in_mode,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_y,
    output logic [CW-1:0]    out_count,
    output logic             out_zero,
    output logic             out_ones,
    output state_e           dbg_state
);

    // Handshake: a beat transfers on a rising edge where valid and ready are both high.
    state_e           r_state;
    state_e           w_state_nxt;
    op_e              r_op;
    op_e              w_op_nxt;
    op_e              w_beat_op;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] w_acc_nxt;
    logic [CW-1:0]    r_count;
    logic [CW-1:0]    w_count_nxt;
    logic [WIDTH-1:0] w_first;
    logic [WIDTH-1:0] w_fold;
    logic [CW-1:0]    w_count_inc;
    logic             w_accept;
    logic             w_push;
    logic [WIDTH-1:0] w_push_y;
    logic [CW-1:0]    w_push_cnt;
    logic             w_pop;
    logic             w_full;
    logic             w_empty;
    logic [WIDTH-1:0] w_head_y;
    logic [CW-1:0]    w_head_cnt;

    function automatic logic [WIDTH-1:0] f_apply(input op_e op, input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b);
        case (op)
            OP_AND:    return a & b;
            OP_OR:     return a | b;
            OP_XOR:    return a ^ b;
            OP_NAND:   return ~(a & b);
            OP_NOR:    return ~(a | b);
            OP_XNOR:   return ~(a ^ b);
            OP_NOT_A:  return ~a;
            default:   return a;
        endcase
    endfunction

    assign in_ready  = ~w_full;
    assign w_accept  = in_valid & in_ready;
    assign w_beat_op = op_e'(in_op);
    assign dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op    <= OP_AND;
            r_acc   <= '0;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_op    <= w_op_nxt;
            r_acc   <= w_acc_nxt;
            r_count <= w_count_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_op_nxt    = r_op;
        w_acc_nxt   = r_acc;
        w_count_nxt = r_count;
        w_push      = 1'b0;
        w_push_y    = '0;
        w_push_cnt  = '0;
        w_first     = is_unary(w_beat_op) ? f_apply(w_beat_op, in_a, in_a) : in_a;
        w_fold      = is_unary(r_op) ? f_apply(r_op, in_a, in_a) : f_apply(r_op, r_acc, in_a);
        w_count_inc = (r_count == '1) ? r_count : r_count + CW'(1);
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (in_mode == MODE_PAIR) begin
                        w_push     = 1'b1;
                        w_push_y   = f_apply(w_beat_op, in_a, in_b);
                        w_push_cnt = CW'(1);
                    end else if (in_mode == MODE_REDUCE) begin
                        if (in_last) begin
                            w_push     = 1'b1;
                            w_push_y   = w_first;
                            w_push_cnt = CW'(1);
                        end else begin
                            w_state_nxt = ST_ACCUM;
                            w_op_nxt    = w_beat_op;
                            w_acc_nxt   = w_first;
                            w_count_nxt = CW'(1);
                        end
                    end
                end
            end
            ST_ACCUM: begin
                // Op and mode stay as latched at frame start; in_op/in_mode are ignored here.
                if (w_accept) begin
                    if (in_last) begin
                        w_push      = 1'b1;
                        w_push_y    = w_fold;
                        w_push_cnt  = w_count_inc;
                        w_state_nxt = ST_IDLE;
                        w_acc_nxt   = '0;
                        w_count_nxt = '0;
                    end else begin
                        w_acc_nxt   = w_fold;
                        w_count_nxt = w_count_inc;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_pop = out_valid & out_ready;

    lgu_fifo #(
        .W     (WIDTH + CW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   ({w_push_y, w_push_cnt}),
        .i_pop   (w_pop),
        .o_dout  ({w_head_y, w_head_cnt}),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    // Outputs are forced to zero while empty so stale FIFO storage never shows.
    assign out_valid = ~w_empty;
    assign out_y     = out_valid ? w_head_y : '0;
    assign out_count = out_valid ? w_head_cnt : '0;
    assign out_zero  = (out_y == '0);
    assign out_ones  = out_valid & (w_head_y == '1);

endmodule

// File: tb/tb_logic_gate_unit.sv
// Directed bench for logic_gate_unit: default instance plus a CW=2 instance for count saturation.
module tb_logic_gate_unit;
    import logic_gate_pkg::*;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_a;
    logic [7:0] in_b;
    logic [2:0] in_op;
    logic       in_mode;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_y;
    logic [7:0] out_count;
    logic       out_zero;
    logic       out_ones;
    state_e     dbg_state;

    logic       s2_in_valid;
    logic       s2_in_ready;
    logic [7:0] s2_in_a;
    logic [7:0] s2_in_b;
    logic [2:0] s2_in_op;
    logic       s2_in_mode;
    logic       s2_in_last;
    logic       s2_out_valid;
    logic       s2_out_ready;
    logic [7:0] s2_out_y;
    logic [1:0] s2_out_count;
    logic       s2_out_zero;
    logic       s2_out_ones;
    state_e     s2_dbg_state;

    int n_checks;
    int n_fail;
    logic [7:0] pw_exp [8];

    logic_gate_unit #(.WIDTH(8), .DEPTH(4), .CW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_mode(in_mode), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y), .out_count(out_count),
        .out_zero(out_zero), .out_ones(out_ones), .dbg_state(dbg_state)
    );

    logic_gate_unit #(.WIDTH(8), .DEPTH(4), .CW(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(s2_in_valid), .in_ready(s2_in_ready),
        .in_a(s2_in_a), .in_b(s2_in_b), .in_op(s2_in_op), .in_mode(s2_in_mode),
        .in_last(s2_in_last), .out_valid(s2_out_valid), .out_ready(s2_out_ready),
        .out_y(s2_out_y), .out_count(s2_out_count), .out_zero(s2_out_zero),
        .out_ones(s2_out_ones), .dbg_state(s2_dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Driver: offers one beat from a falling edge and holds it until accepted.
    task automatic send(input logic [2:0] op, input logic mode, input logic last,
                        input logic [7:0] a, input logic [7:0] b);
        int n;
        @(negedge clk);
        in_op    = op;
        in_mode  = mode;
        in_last  = last;
        in_a     = a;
        in_b     = b;
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_ready", 64'(in_ready), 64'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Checks the FIFO head on the next falling edge, then pops it.
    task automatic expect_out(input string tag, input logic [7:0] y, input logic [7:0] cnt);
        @(negedge clk);
        chk({tag, "_valid"}, 64'(out_valid), 64'h1);
        chk({tag, "_y"}, 64'(out_y), 64'(y));
        chk({tag, "_count"}, 64'(out_count), 64'(cnt));
        chk({tag, "_zero"}, 64'(out_zero), 64'(y == 8'h00));
        chk({tag, "_ones"}, 64'(out_ones), 64'(y == 8'hFF));
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        pw_exp   = '{8'h30, 8'hFC, 8'hCC, 8'hCF, 8'h03, 8'h33, 8'h0F, 8'hF0};
        rst = 1'b1;
        in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_mode = 1'b0; in_last = 1'b0;
        out_ready = 1'b0;
        s2_in_valid = 1'b0; s2_in_a = '0; s2_in_b = '0; s2_in_op = '0;
        s2_in_mode = 1'b0; s2_in_last = 1'b0; s2_out_ready = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_valid", 64'(out_valid), 64'h0);
        chk("rst_y", 64'(out_y), 64'h0);
        chk("rst_count", 64'(out_count), 64'h0);
        chk("rst_zero", 64'(out_zero), 64'h1);
        chk("rst_ones", 64'(out_ones), 64'h0);
        chk("rst_ready", 64'(in_ready), 64'h1);
        chk("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        chk("rst_sat_valid", 64'(s2_out_valid), 64'h0);
        rst = 1'b0;

        // Pairwise ops on F0 / 3C
        for (int i = 0; i < 8; i++) begin
            send(i[2:0], MODE_PAIR, 1'b0, 8'hF0, 8'h3C);
            expect_out($sformatf("pw_op%0d", i), pw_exp[i], 8'd1);
        end

        // Reduce XOR frame 01,02,04
        send(3'd2, MODE_REDUCE, 1'b0, 8'h01, 8'hAA);
        @(negedge clk);
        chk("xor_b1_novalid", 64'(out_valid), 64'h0);
        chk("xor_b1_state", 64'(dbg_state), 64'(ST_ACCUM));
        send(3'd2, MODE_REDUCE, 1'b0, 8'h02, 8'h55);
        @(negedge clk);
        chk("xor_b2_novalid", 64'(out_valid), 64'h0);
        send(3'd2, MODE_REDUCE, 1'b1, 8'h04, 8'hFF);
        expect_out("xor_frame", 8'h07, 8'd3);
        chk("xor_state_idle", 64'(dbg_state), 64'(ST_IDLE));

        // Mid-frame op change is ignored: AND of FF then 0F
        send(3'd0, MODE_REDUCE, 1'b0, 8'hFF, 8'h00);
        send(3'd1, MODE_PAIR, 1'b1, 8'h0F, 8'hF0);
        expect_out("opchg", 8'h0F, 8'd2);

        // Single-beat reduce frames
        send(3'd6, MODE_REDUCE, 1'b1, 8'h5A, 8'h00);
        expect_out("single_not", 8'hA5, 8'd1);
        send(3'd0, MODE_REDUCE, 1'b1, 8'h3C, 8'h00);
        expect_out("single_and", 8'h3C, 8'd1);

        // Zero flag
        send(3'd0, MODE_PAIR, 1'b0, 8'h00, 8'hFF);
        expect_out("flag_zero", 8'h00, 8'd1);

        // Reset mid-frame discards the partial frame
        send(3'd0, MODE_REDUCE, 1'b0, 8'hFF, 8'h00);
        send(3'd0, MODE_REDUCE, 1'b0, 8'hAA, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_state", 64'(dbg_state), 64'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_novalid", 64'(out_valid), 64'h0);
        send(3'd0, MODE_PAIR, 1'b0, 8'hFF, 8'hFF);
        expect_out("midrst_and", 8'hFF, 8'd1);
        @(negedge clk);
        chk("midrst_only_one", 64'(out_valid), 64'h0);

        // Backpressure: fill, hold, then drain in order
        for (int i = 0; i < 4; i++) begin
            send(3'd7, MODE_PAIR, 1'b0, 8'h10 + i[7:0], 8'h00);
        end
        @(negedge clk);
        chk("bp_full_ready", 64'(in_ready), 64'h0);
        chk("bp_head", 64'(out_y), 64'h10);
        in_a = 8'h14; in_b = 8'h00; in_op = 3'd7; in_mode = MODE_PAIR; in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_hold_ready", 64'(in_ready), 64'h0);
            chk("bp_hold_y", 64'(out_y), 64'h10);
            chk("bp_hold_count", 64'(out_count), 64'h1);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_drain1_y", 64'(out_y), 64'h11);
        chk("bp_drain1_ready", 64'(in_ready), 64'h1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drain2_y", 64'(out_y), 64'h12);
        @(negedge clk);
        chk("bp_drain3_y", 64'(out_y), 64'h13);
        @(negedge clk);
        chk("bp_drain4_y", 64'(out_y), 64'h14);
        chk("bp_drain4_valid", 64'(out_valid), 64'h1);
        @(negedge clk);
        chk("bp_empty", 64'(out_valid), 64'h0);
        out_ready = 1'b0;

        // Count saturation on the CW=2 instance: 5-beat AND frame of FF
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            s2_in_op = 3'd0; s2_in_mode = MODE_REDUCE; s2_in_a = 8'hFF; s2_in_b = 8'h00;
            s2_in_last = (i == 4); s2_in_valid = 1'b1;
            @(posedge clk);
            #1;
            s2_in_valid = 1'b0;
            s2_in_last  = 1'b0;
            if (i == 3) begin
                @(negedge clk);
                chk("sat_novalid", 64'(s2_out_valid), 64'h0);
            end
        end
        @(negedge clk);
        chk("sat_valid", 64'(s2_out_valid), 64'h1);
        chk("sat_y", 64'(s2_out_y), 64'hFF);
        chk("sat_count", 64'(s2_out_count), 64'h3);
        chk("sat_ones", 64'(s2_out_ones), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/logic_gate_unit.md
LOGIC_GATE_UNIT -- requirements
Module: logic_gate_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand/result width in bits, legal 1..64.
REQ-002 SHALL have parameter DEPTH, default 4: output FIFO entries, power of two, legal 2..16.
REQ-003 SHALL have parameter CW, default 8: beat-count width in bits.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: input beat offered.
REQ-007 SHALL have port in_ready, output, 1 bit: input beat can be accepted.
REQ-008 SHALL have ports in_a and in_b, inputs, WIDTH bits each: operands.
REQ-009 SHALL have port in_op, input, 3 bits: 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT_A, 7 PASS_A.
REQ-010 SHALL have port in_mode, input, 1 bit: 0 pairwise, 1 reduce.
REQ-011 SHALL have port in_last, input, 1 bit: final beat of a reduce frame.
REQ-012 SHALL have port out_valid, output, 1 bit: result available.
REQ-013 SHALL have port out_ready, input, 1 bit: result consumed.
REQ-014 SHALL have port out_y, output, WIDTH bits: result.
REQ-015 SHALL have port out_count, output, CW bits: number of beats folded into the result.
REQ-016 SHALL have ports out_zero and out_ones, outputs, 1 bit each: out_y all-zeros / all-ones.

Function
REQ-017 SHALL accept a beat only when in_valid and in_ready are both high; in_ready = FIFO not full.
REQ-018 SHALL, for a pairwise beat (in_mode=0), push {in_a OP in_b, count=1}; NOT_A = ~in_a; PASS_A = in_a.
REQ-019 SHALL run the FSM IDLE -> ACCUM on an accepted reduce beat with in_last=0, and ACCUM -> IDLE on an accepted beat with in_last=1.
REQ-020 SHALL latch op and mode on the first beat of a frame; in_op/in_mode on later beats of the frame are ignored.
REQ-021 SHALL load acc=in_a, count=1 on the first reduce beat, then set acc = acc OP in_a, count+1 per beat; in_b is ignored in reduce mode.
REQ-022 SHALL, for ops 6/7 in reduce mode, set acc = op(in_a) of the current beat.
REQ-023 SHALL push {acc result, count} only on the in_last beat; a single-beat reduce frame yields op(in_a) for ops 6/7 and in_a otherwise, with count=1.
REQ-024 SHALL saturate count at 2^CW-1.
REQ-025 SHALL present a pushed result with out_valid high on the cycle after the accepting edge, a latency of 1.
REQ-026 SHALL pop on out_valid and out_ready; a simultaneous push and pop leaves occupancy unchanged.
REQ-027 SHALL hold out_y, out_count, out_zero and out_ones stable while out_valid=1 and out_ready=0.
REQ-028 SHALL derive out_zero and out_ones from the FIFO head.
REQ-029 SHALL deassert in_ready whenever the FIFO is full, including for non-emitting reduce beats.

Reset
REQ-030 SHALL, on rst, empty the FIFO, clear acc and count, and set the FSM to IDLE.
REQ-031 SHALL drive outputs to these reset values: out_valid=0, out_y=0, out_count=0, out_zero=1, out_ones=0, in_ready=1.
REQ-032 SHALL discard a partial frame when reset occurs mid-frame; no result is emitted for it.

Structure
REQ-033 SHALL define the op enum, mode constants and FSM state type in shared package logic_gate_pkg.
REQ-034 SHALL implement the output buffer as sub-module lgu_fifo, a synchronous FIFO parametrised by WIDTH+CW and DEPTH.

Verification
REQ-035 SHALL cover pairwise ops: a=8'hF0, b=8'h3C with op 0..7 -> y = 30, FC, CC, CF, 03, 33, 0F, F0; count=1 for each.
REQ-036 SHALL cover a reduce XOR frame: a = 01, 02, 04 with last on the 3rd beat -> a single result y=07, count=3, and no output before the last beat.
REQ-037 SHALL cover backpressure: out_ready=0 with DEPTH+1 pairwise beats offered -> in_ready=0 after DEPTH accepts; the head holds stable; results drain in order when out_ready=1.
REQ-038 SHALL cover a mid-frame op change: a reduce AND frame started with FF, then a beat carrying in_op=OR and a=0F, last -> y=0F, count=2.
REQ-039 SHALL cover reset mid-frame: 2 beats of a reduce frame, then rst, then a pairwise AND FF&FF -> the only output is y=FF, count=1, out_ones=1.
REQ-040 SHALL cover flags and saturation: AND 00&FF -> out_zero=1; with CW=2, a 5-beat frame -> count=3.
